booth2_mul_arb: RTL and testbench

- Shared-multiplier controller for the 4x4 signed radix-4 Booth datapath.
- Arbitrates two requesters onto one Booth encoder plus one internal instance of the team's `cra` partial-product adder.
- Sequences each operation through encode and add stages, and returns the 8-bit signed product with the requester's tag over a valid/ready response channel.

---
 rtl/booth2_mul_arb.sv | 268 ++++++++++++++++++++++++++
 tb/tb_booth2_mul_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth2_mul_arb.sv
// booth2_mul_arb: two-requester front end for a shared 4x4 signed radix-4
// Booth multiplier. A request is latched in IDLE, Booth-encoded in ENC,
// summed by the cra partial-product adder in ADD, and held in RESP until
// the consumer takes it.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.

// cra: sums the two Booth partial products (row 1 weighted by 4) with
// their negate bits. The e bits stand in for sign extension: each row gets
// a small constant in place of its replicated sign bit, and the two
// constants cancel mod 256. A 3:2 compressor merges the rows, then a ripple
// adder produces the 8-bit product.
module cra (
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [1:0] s,
    input  logic [1:0] e,
    output logic [7:0] sum
);
    logic [7:0] row_a;
    logic [7:0] row_b;
    logic [7:0] row_c;
    logic [7:0] cs_sum;
    logic [7:0] cs_carry;
    logic [7:0] rc_in;
    logic [7:0] rc_carry;

    // row_a = signed(in0) + 64; row_b = 4*signed(in1) - 64 (mod 256).
    // e is the complement of each row's sign bit, so bit 7 of row_b is
    // always 1.
    assign row_a = {1'b0, e[0], in0[4], in0[4], in0[3:0]};
    assign row_b = {e[1] | in1[4], e[1], in1[3:0], 2'b00};
    assign row_c = {5'b00000, s[1], 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_csa
            assign cs_sum[gi] = row_a[gi] ^ row_b[gi] ^ row_c[gi];
            if (gi < 7) begin : g_cy
                assign cs_carry[gi + 1] = (row_a[gi] & row_b[gi]) |
                                          (row_a[gi] & row_c[gi]) |
                                          (row_b[gi] & row_c[gi]);
            end
        end
    endgenerate

    // The free carry slot at bit 0 takes the row-0 negate bit.
    assign cs_carry[0] = s[0];
    assign rc_in       = cs_carry;
    assign rc_carry[0] = 1'b0;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_rca
            assign sum[gi] = cs_sum[gi] ^ rc_in[gi] ^ rc_carry[gi];
            if (gi < 7) begin : g_cy
                assign rc_carry[gi + 1] = (cs_sum[gi] & rc_in[gi]) |
                                          (cs_sum[gi] & rc_carry[gi]) |
                                          (rc_in[gi] & rc_carry[gi]);
            end
        end
    endgenerate
endmodule

module booth2_mul_arb #(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_prod,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag
);
    typedef enum logic [1:0] {IDLE, ENC, ADD, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             id_q, id_d;
    logic [4:0]       pp0_q, pp0_d;
    logic [4:0]       pp1_q, pp1_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       e_q, e_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_prod_q, rsp_prod_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
`ifdef ARB_RR_EN
    logic             ptr_q, ptr_d;
`endif

    logic             grant0;
    logic             grant1;
    logic [4:0]       b_ext;
    logic [4:0]       pp_enc [2];
    logic [1:0]       s_enc;
    logic [1:0]       e_enc;
    logic [7:0]       cra_sum;

    // Booth digit i looks at multiplier bits (2i+1, 2i, 2i-1), with b[-1]=0.
    assign b_ext = {b_q, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_booth
            logic [2:0] trip;
            logic       one;
            logic       two;
            logic       neg;
            logic [4:0] mag;

            assign trip = b_ext[2*gi+2 -: 3];
            assign one  = trip[1] ^ trip[0];
            assign two  = (trip[2] & ~trip[1] & ~trip[0]) |
                          (~trip[2] & trip[1] & trip[0]);
            // 3'b111 is digit 0, so it must not raise neg.
            assign neg  = trip[2] & ~(trip[1] & trip[0]);
            assign mag  = one ? {a_q[3], a_q} : (two ? {a_q, 1'b0} : 5'd0);
            assign pp_enc[gi] = mag ^ {5{neg}};
            assign s_enc[gi]  = neg;
            assign e_enc[gi]  = ~pp_enc[gi][4];
        end
    endgenerate

    cra u_cra (
        .in0 (pp0_q),
        .in1 (pp1_q),
        .s   (s_q),
        .e   (e_q),
        .sum (cra_sum)
    );

    // Arbitration: which valid port would win if we were idle.
    always_comb begin
`ifdef ARB_RR_EN
        grant0 = req0_valid & (~req1_valid | ~ptr_q);
        grant1 = req1_valid & (~req0_valid | ptr_q);
`else
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`endif
    end

    // Next-state, datapath captures and ready outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        id_d        = id_q;
        pp0_d       = pp0_q;
        pp1_d       = pp1_q;
        s_d         = s_q;
        e_d         = e_q;
        rsp_valid_d = rsp_valid_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
`ifdef ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                if (grant0) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    tag_d   = req0_tag;
                    id_d    = 1'b0;
                    state_d = ENC;
`ifdef ARB_RR_EN
                    ptr_d   = 1'b1;
`endif
                end else if (grant1) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    tag_d   = req1_tag;
                    id_d    = 1'b1;
                    state_d = ENC;
`ifdef ARB_RR_EN
                    ptr_d   = 1'b0;
`endif
                end
            end
            ENC: begin
                pp0_d   = pp_enc[0];
                pp1_d   = pp_enc[1];
                s_d     = s_enc;
                e_d     = e_enc;
                state_d = ADD;
            end
            ADD: begin
                rsp_prod_d  = cra_sum;
                rsp_id_d    = id_q;
                rsp_tag_d   = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            id_q        <= 1'b0;
            pp0_q       <= '0;
            pp1_q       <= '0;
            s_q         <= '0;
            e_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
`ifdef ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            id_q        <= id_d;
            pp0_q       <= pp0_d;
            pp1_q       <= pp1_d;
            s_q         <= s_d;
            e_q         <= e_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
`ifdef ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_booth2_mul_arb.sv
// Testbench for booth2_mul_arb: table-driven corner products, exhaustive
// and random operations against an arithmetic reference, backpressure,
// mid-operation reset and two-port contention.
module tb_booth2_mul_arb;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [3:0]       req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [3:0]       req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp_valid, rsp_ready;
    logic [7:0]       rsp_prod;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] tag;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [5];

    booth2_mul_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain signed multiplication, truncated to 8 bits.
    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        int p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[7:0];
    endfunction

    task automatic do_op(input int port, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] tag, input int hold, input logic [7:0] exp);
        int   n;
        logic rdy;
        @(negedge clk);
        rsp_ready = (hold == 0);
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag;
        end
        n = 0;
        #1;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 8) begin
            @(negedge clk);
            #1;
            rdy = (port == 0) ? req0_ready : req1_ready;
            n++;
        end
        chk("grant", int'(rdy), 1);
        if (!rdy) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Operands change after the handshake; the product must not.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
        chk("rsp_prod", int'(rsp_prod), int'(exp));
        chk("rsp_id", int'(rsp_id), port);
        chk("rsp_tag", int'(rsp_tag), int'(tag));
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            chk("bp_ready0", int'(req0_ready), 0);
            chk("bp_ready1", int'(req1_ready), 0);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_prod", int'(rsp_prod), int'(exp));
            chk("bp_id", int'(rsp_id), port);
            chk("bp_tag", int'(rsp_tag), int'(tag));
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_cleared", int'(rsp_valid), 0);
        $display("op port=%0d a=%0d b=%0d tag=%0d hold=%0d prod=%0d expected=%0d",
                 port, $signed(a), $signed(b), tag, hold, $signed(rsp_prod), $signed(exp));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int       grants [$];
        int       ids [$];
        int       n;
        logic [3:0] ra, rb;

        tbl[0] = '{4'h8, 4'h8, 2'd1, 8'h40};
        tbl[1] = '{4'h7, 4'h8, 2'd2, 8'hC8};
        tbl[2] = '{4'h8, 4'h7, 2'd3, 8'hC8};
        tbl[3] = '{4'h0, 4'hB, 2'd0, 8'h00};
        tbl[4] = '{4'hF, 4'hF, 2'd1, 8'h01};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
        rsp_ready = 1'b0;

        // Reset state, including readys held low while valids are high.
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_prod", int'(rsp_prod), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_tag", int'(rsp_tag), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready0", int'(req0_ready), 0);
            chk("idle_ready1", int'(req1_ready), 0);
            chk("idle_valid", int'(rsp_valid), 0);
        end

        // Single op on port 0.
        do_op(0, 4'd3, 4'd5, 2'd2, 0, 8'h0F);

        // Corner products on port 1.
        for (int i = 0; i < 5; i++)
            do_op(1, tbl[i].a, tbl[i].b, tbl[i].tag, 0, tbl[i].exp);

        // Backpressure for 5 cycles.
        do_op(0, 4'h6, 4'hB, 2'd3, 5, 8'hE2);

        // Reset while the operation sits in ADD.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_tag = 2'd1;
        #1;
        chk("ma_ready", int'(req0_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ma_valid_rst", int'(rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ma_no_rsp", int'(rsp_valid), 0);
        end
        chk("ma_prod", int'(rsp_prod), 0);
        do_op(1, 4'd2, 4'hD, 2'd2, 0, ref_prod(4'd2, 4'hD));

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) begin
            ra = 4'(i >> 4);
            rb = 4'(i);
            do_op(i % 2, ra, rb, 2'(i), 0, ref_prod(ra, rb));
        end

        // Random operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_op(int'($urandom_range(0, 1)), ra, rb, 2'($urandom),
                  int'($urandom_range(0, 3)), ref_prod(ra, rb));
        end

        // Contention: both ports valid continuously from a fresh reset.
        apply_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_tag = 2'd1;
        req1_valid = 1'b1; req1_a = 4'hD; req1_b = 4'd5; req1_tag = 2'd2;
        n = 0;
        while ((grants.size() < 4 || ids.size() < 4) && n < 60) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                chk("cont_prod", int'(rsp_prod),
                    int'(rsp_id ? ref_prod(4'hD, 4'd5) : ref_prod(4'd2, 4'd3)));
            end
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_grants_seen", int'(grants.size() >= 4), 1);
        chk("cont_rsps_seen", int'(ids.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            if (k < grants.size()) chk("cont_grant", grants[k], k % 2);
            if (k < ids.size()) chk("cont_rsp_id", ids[k], k % 2);
`else
            if (k < grants.size()) chk("cont_grant", grants[k], 0);
            if (k < ids.size()) chk("cont_rsp_id", ids[k], 0);
`endif
            if (k < grants.size() && k < ids.size())
                $display("contention grant=%0d rsp_id=%0d", grants[k], ids[k]);
        end

        repeat (6) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
